// File: rtl/shift_register_sequencer_if.sv
// rtl/shift_register_sequencer_if.sv - command/response handshake bundle for shift_register_sequencer
// Carries abort/rsp_abort only when SR_SEQ_ABORT_EN is defined.
interface shift_register_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [3:0] cmd_count;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
`ifdef SR_SEQ_ABORT_EN
  logic       abort;
  logic       rsp_abort;

  modport master (
    output cmd_valid, cmd_dir, cmd_count, cmd_data, rsp_ready, abort,
    input  cmd_ready, rsp_valid, rsp_data, rsp_abort
  );
  modport slave (
    input  cmd_valid, cmd_dir, cmd_count, cmd_data, rsp_ready, abort,
    output cmd_ready, rsp_valid, rsp_data, rsp_abort
  );
`else
  modport master (
    output cmd_valid, cmd_dir, cmd_count, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  cmd_valid, cmd_dir, cmd_count, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
`endif
endinterface

// File: rtl/shift_register_sequencer.sv
// rtl/shift_register_sequencer.sv - load/shift/capture sequencer driving an 8-bit bidirectional shift register
// Optional early-abort path is built when SR_SEQ_ABORT_EN is defined.
module shift_register_sequencer #(
  parameter int MAX_SHIFT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  shift_register_sequencer_if.slave  bus,
  output logic [1:0]                 sr_ctrl,
  output logic [7:0]                 sr_data,
  input  logic [7:0]                 sr_q,
  output logic                       busy
);
  localparam logic [3:0] MAX_CNT    = 4'(MAX_SHIFT);
  localparam logic [1:0] CTRL_HOLD  = 2'b00;
  localparam logic [1:0] CTRL_LEFT  = 2'b01;
  localparam logic [1:0] CTRL_RIGHT = 2'b10;
  localparam logic [1:0] CTRL_LOAD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       dir_q, dir_d;
  logic [7:0] data_q, data_d;
  logic [1:0] sr_ctrl_q, sr_ctrl_d;
  logic [7:0] sr_data_q, sr_data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       abort_hit;

`ifdef SR_SEQ_ABORT_EN
  logic aborted_q, aborted_d;
  logic rsp_abort_q, rsp_abort_d;
  assign abort_hit     = bus.abort;
  assign bus.rsp_abort = rsp_abort_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dir_d       = dir_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef SR_SEQ_ABORT_EN
    aborted_d   = aborted_q;
    rsp_abort_d = rsp_abort_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d = S_LOAD;
          dir_d   = bus.cmd_dir;
          count_d = (bus.cmd_count > MAX_CNT) ? MAX_CNT : bus.cmd_count;
          data_d  = bus.cmd_data;
`ifdef SR_SEQ_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        state_d = (abort_hit || count_q == 4'd0) ? S_CAPTURE : S_SHIFT;
      end
      S_SHIFT: begin
        // The shift driven this cycle lands at the same edge, even on abort.
        count_d = count_q - 4'd1;
        if (abort_hit || count_q <= 4'd1) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        rsp_data_d  = sr_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
`ifdef SR_SEQ_ABORT_EN
        rsp_abort_d = aborted_q;
`endif
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
`ifdef SR_SEQ_ABORT_EN
          rsp_abort_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SR_SEQ_ABORT_EN
    if ((state_q == S_LOAD || state_q == S_SHIFT) && abort_hit) aborted_d = 1'b1;
`endif

    // Pin drive is registered: decode it from where the FSM is heading.
    sr_ctrl_d = CTRL_HOLD;
    sr_data_d = 8'h00;
    if (state_d == S_LOAD) begin
      sr_ctrl_d = CTRL_LOAD;
      sr_data_d = data_d;
    end else if (state_d == S_SHIFT) begin
      sr_ctrl_d = dir_d ? CTRL_RIGHT : CTRL_LEFT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= 4'd0;
      dir_q       <= 1'b0;
      data_q      <= 8'h00;
      sr_ctrl_q   <= CTRL_HOLD;
      sr_data_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
`ifdef SR_SEQ_ABORT_EN
      aborted_q   <= 1'b0;
      rsp_abort_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      data_q      <= data_d;
      sr_ctrl_q   <= sr_ctrl_d;
      sr_data_q   <= sr_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef SR_SEQ_ABORT_EN
      aborted_q   <= aborted_d;
      rsp_abort_q <= rsp_abort_d;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign sr_ctrl       = sr_ctrl_q;
  assign sr_data       = sr_data_q;

endmodule

// File: tb/tb_shift_register_sequencer.sv
// tb/tb_shift_register_sequencer.sv - self-checking bench for shift_register_sequencer with a zero-fill shift register
`timescale 1ns/1ps
module tb_shift_register_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sr_ctrl;
  logic [7:0] sr_data;
  logic [7:0] sr_q;
  logic       busy;

  always #5 clk = ~clk;

  shift_register_sequencer_if bus();

  shift_register_sequencer #(.MAX_SHIFT(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .sr_ctrl (sr_ctrl),
    .sr_data (sr_data),
    .sr_q    (sr_q),
    .busy    (busy)
  );

  // Shift register being sequenced: vacated bits fill with 0.
  always @(posedge clk or posedge reset) begin
    if (reset) sr_q <= 8'h00;
    else begin
      case (sr_ctrl)
        2'b01:   sr_q <= {sr_q[6:0], 1'b0};
        2'b10:   sr_q <= {1'b0, sr_q[7:1]};
        2'b11:   sr_q <= sr_data;
        default: sr_q <= sr_q;
      endcase
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] shifted(input logic [7:0] v, input bit right, input int n);
    int w;
    w = int'(v);
    if (right) w = w / (1 << n);
    else       w = (w * (1 << n)) % 256;
    return w[7:0];
  endfunction

  // Behavioural model: t counts edges since accept; n is the effective shift count.
  bit         m_busy = 1'b0;
  bit         m_rsp = 1'b0;
  bit         m_rabort = 1'b0;
  bit         m_dir = 1'b0;
  int         m_t = 0;
  int         m_n = 0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_res = 8'h00;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_busy = 1'b0; m_rsp = 1'b0; m_rabort = 1'b0; m_t = 0;
    end else if (!m_busy) begin
      if (bus.cmd_valid) begin
        m_busy   = 1'b1;
        m_t      = 0;
        m_n      = (int'(bus.cmd_count) > 8) ? 8 : int'(bus.cmd_count);
        m_dir    = bus.cmd_dir;
        m_data   = bus.cmd_data;
        m_rabort = 1'b0;
        m_res    = shifted(m_data, m_dir, m_n);
      end
    end else if (m_rsp) begin
      if (bus.rsp_ready) begin
        m_busy = 1'b0; m_rsp = 1'b0;
      end
    end else begin
`ifdef SR_SEQ_ABORT_EN
      if (bus.abort && m_t <= m_n) begin
        m_n      = m_t;
        m_rabort = 1'b1;
        m_res    = shifted(m_data, m_dir, m_n);
      end
`endif
      m_t++;
      if (m_t == m_n + 2) m_rsp = 1'b1;
    end
  end

  bit         chk_en = 1'b0;
  logic [1:0] e_ctrl;
  logic [7:0] e_data;

  always @(negedge clk) begin
    if (chk_en) begin
      e_ctrl = 2'b00;
      e_data = 8'h00;
      if (m_busy && !m_rsp) begin
        if (m_t == 0) begin
          e_ctrl = 2'b11;
          e_data = m_data;
        end else if (m_t <= m_n) begin
          e_ctrl = m_dir ? 2'b10 : 2'b01;
        end
      end
      check("cyc_cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy));
      check("cyc_busy",      32'(busy),          32'(m_busy));
      check("cyc_sr_ctrl",   32'(sr_ctrl),       32'(e_ctrl));
      check("cyc_sr_data",   32'(sr_data),       32'(e_data));
      check("cyc_rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp));
      if (m_rsp) begin
        check("cyc_rsp_data", 32'(bus.rsp_data), 32'(m_res));
`ifdef SR_SEQ_ABORT_EN
        check("cyc_rsp_abort", 32'(bus.rsp_abort), 32'(m_rabort));
`endif
      end
    end
  end

  logic [1:0] ctrl_log[$];

  // Issues one command, returns accept wait, accept-to-response latency and response data.
  task automatic run_cmd(input bit d, input logic [3:0] c, input logic [7:0] v, input bit keep_valid,
                         output int waited, output int lat, output logic [7:0] got);
    bus.cmd_dir   = d;
    bus.cmd_count = c;
    bus.cmd_data  = v;
    bus.cmd_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus.cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", 32'(waited < 20), 32'd1);
    @(posedge clk); #1;
    if (!keep_valid) bus.cmd_valid = 1'b0;
    ctrl_log.delete();
    lat = 0;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 30) begin
      ctrl_log.push_back(sr_ctrl);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got = bus.rsp_data;
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  int         waited, lat, nshift;
  logic [7:0] got, held;
  logic [1:0] exp2[5];

  initial begin
    reset         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_count = 4'd0;
    bus.cmd_data  = 8'h00;
    bus.rsp_ready = 1'b0;
`ifdef SR_SEQ_ABORT_EN
    bus.abort     = 1'b0;
`endif
    #3 reset = 1'b1;
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_sr_ctrl",   32'(sr_ctrl),       32'd0);
    check("rst_sr_data",   32'(sr_data),       32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready",   32'(bus.cmd_ready), 32'd1);
    check("post_rst_sr_ctrl", 32'(sr_ctrl),       32'd0);

    // 0xA5 left by 3
    exp2 = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b00};
    run_cmd(1'b0, 4'd3, 8'hA5, 1'b0, waited, lat, got);
    check("t2_latency", 32'(lat), 32'd5);
    check("t2_rsp_data", 32'(got), 32'h28);
    check("t2_model", 32'(m_res), 32'h28);
    check("t2_ctrl_len", 32'(ctrl_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < ctrl_log.size()) check("t2_ctrl_seq", 32'(ctrl_log[i]), 32'(exp2[i]));
    finish_rsp();

    // 0x3C right by 0: no shift codes
    run_cmd(1'b1, 4'd0, 8'h3C, 1'b0, waited, lat, got);
    check("t3_latency", 32'(lat), 32'd2);
    check("t3_rsp_data", 32'(got), 32'h3C);
    nshift = 0;
    foreach (ctrl_log[i]) if (ctrl_log[i] == 2'b01 || ctrl_log[i] == 2'b10) nshift++;
    check("t3_no_shift", 32'(nshift), 32'd0);
    finish_rsp();

    // 0xFF right by 12 clamps to 8
    run_cmd(1'b1, 4'd12, 8'hFF, 1'b0, waited, lat, got);
    check("t4_latency", 32'(lat), 32'd10);
    check("t4_rsp_data", 32'(got), 32'h00);
    check("t4_model_n", 32'(m_n), 32'd8);
    nshift = 0;
    foreach (ctrl_log[i]) if (ctrl_log[i] == 2'b10) nshift++;
    check("t4_shift_cycles", 32'(nshift), 32'd8);
    finish_rsp();

    // Response back-pressure with cmd_valid held high
    run_cmd(1'b0, 4'd2, 8'h81, 1'b1, waited, lat, got);
    check("t5_rsp_data", 32'(got), 32'h04);
    held = got;
    bus.cmd_dir   = 1'b1;
    bus.cmd_count = 4'd1;
    bus.cmd_data  = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("t5_hold_data", 32'(bus.rsp_data), 32'(held));
      check("t5_hold_ready", 32'(bus.cmd_ready), 32'd0);
      check("t5_hold_valid", 32'(bus.rsp_valid), 32'd1);
    end
    finish_rsp();
    run_cmd(1'b1, 4'd1, 8'h0F, 1'b0, waited, lat, got);
    check("t5_accept_gap", 32'(waited), 32'd0);
    check("t5_latency2", 32'(lat), 32'd3);
    check("t5_rsp_data2", 32'(got), 32'h07);
    finish_rsp();

    // Reset pulse during SHIFT
    bus.cmd_dir   = 1'b0;
    bus.cmd_count = 4'd6;
    bus.cmd_data  = 8'h5A;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    check("t6_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("t6_in_shift", 32'(sr_ctrl), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t6_sr_ctrl", 32'(sr_ctrl), 32'd0);
    check("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

`ifdef SR_SEQ_ABORT_EN
    // Abort in the second SHIFT cycle: two shifts land
    bus.cmd_dir   = 1'b0;
    bus.cmd_count = 4'd5;
    bus.cmd_data  = 8'h01;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t7_rsp_data", 32'(bus.rsp_data), 32'h04);
    check("t7_rsp_abort", 32'(bus.rsp_abort), 32'd1);
    check("t7_model", 32'(m_res), 32'h04);
    finish_rsp();
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
